// File: rtl/mem_readout_scanner.sv
// Sequential reader for the processor's parallel memory port: issues credit-limited
// reads, captures q after READ_LAT cycles and streams the words through a skid FIFO.
module mem_readout_scanner #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 16,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic [ADDR_W-1:0] parallelAddress,
    input  logic [DATA_W-1:0] q,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    // One stage for the registered address plus READ_LAT stages of memory latency.
    localparam int PIPE_D = READ_LAT + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + PIPE_D + 2);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    state_t              state, stateNext;
    logic [ADDR_W-1:0]   nextAddr;
    logic [CNT_W-1:0]    remaining;
    logic [CNT_W-1:0]    wordLen;
    logic [CNT_W-1:0]    capCount;
    logic [PIPE_D-1:0]   pipeValid;

    logic [DATA_W-1:0]   fifoData [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifoLast;
    logic [PTR_W-1:0]    rdPtr, wrPtr;
    logic [FCNT_W-1:0]   fifoCount;

    logic                issue, loadScan, push, pop, canIssue, captureLast;
    logic [ADDR_W-1:0]   issueAddr;
    logic [CNT_W-1:0]    scanRemaining;
    logic [OCC_W-1:0]    inflight;

    assign push        = pipeValid[PIPE_D-1];
    assign m_valid     = (fifoCount != '0);
    assign pop         = m_valid && m_ready;
    assign m_data      = m_valid ? fifoData[rdPtr] : '0;
    assign m_last      = m_valid && fifoLast[rdPtr];
    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign captureLast = (capCount == wordLen - CNT_W'(1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_D; i++) begin
            inflight = inflight + OCC_W'(pipeValid[i]);
        end
    end

    // A word popped this cycle frees its slot in time for a read issued now.
    assign canIssue = (OCC_W'(fifoCount) + inflight) < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));

    assign issueAddr     = (state == IDLE) ? base_addr : nextAddr;
    assign scanRemaining = loadScan ? word_count : remaining;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        stateNext = state;
        issue     = 1'b0;
        loadScan  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    loadScan = 1'b1;
                    if (word_count == '0) begin
                        stateNext = FINISH;
                    end else begin
                        // The first read leaves with the start edge so its address shows in cycle 1.
                        issue     = 1'b1;
                        stateNext = (word_count == CNT_W'(1)) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (canIssue) begin
                    issue = 1'b1;
                    if (remaining == CNT_W'(1)) stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && fifoLast[rdPtr]) stateNext = FINISH;
            end
            FINISH: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state           <= IDLE;
            parallelAddress <= '0;
            nextAddr        <= '0;
            remaining       <= '0;
            wordLen         <= '0;
            capCount        <= '0;
            pipeValid       <= '0;
        end else begin
            state     <= stateNext;
            pipeValid <= {pipeValid[PIPE_D-2:0], issue};
            if (loadScan) begin
                wordLen  <= word_count;
                capCount <= '0;
            end else if (push) begin
                capCount <= capCount + CNT_W'(1);
            end
            if (issue) begin
                parallelAddress <= issueAddr;
                nextAddr        <= issueAddr + ADDR_W'(1);
                remaining       <= scanRemaining - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifoCount <= fifoCount + FCNT_W'(1);
                2'b01:   fifoCount <= fifoCount - FCNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // NOTE: storage is left unreset; outputs are masked by m_valid, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoData[wrPtr] <= q;
            fifoLast[wrPtr] <= captureLast;
        end
    end

endmodule

// File: doc/mem_readout_scanner.md
# mem_readout_scanner

External-side reader for the processor's parallel memory read port. It drives `parallelAddress`, samples the returned `q` data after a fixed read latency, and streams the words out on a valid/ready interface (display, UART or host link). It sits outside `processor`, and its own `parallelAddress`/`q` ports connect directly to the processor ports of the same name.

## Interface
Parameters:
- ADDR_W, 24, width of `parallelAddress` and of `base_addr`.
- DATA_W, 16, width of `q` and `m_data`.
- CNT_W, 16, width of `word_count`.
- READ_LAT, 2, cycles from an address presented on `parallelAddress` to the matching valid `q`; legal range 1..4.
- FIFO_DEPTH, 4, output skid FIFO entries; power of two, at least 2.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request to begin a scan; sampled only in IDLE.
- base_addr, input, ADDR_W, first word address; latched on accepted `start`.
- word_count, input, CNT_W, number of words to read; latched on accepted `start`.
- parallelAddress, output, ADDR_W, registered read address to the processor.
- q, input, DATA_W, read data from the processor; valid READ_LAT cycles after the address.
- m_valid, output, 1, output word available.
- m_ready, input, 1, downstream accepts the word when high together with `m_valid`.
- m_data, output, DATA_W, output word.
- m_last, output, 1, high with the final word of a scan.
- busy, output, 1, high from an accepted `start` until the `done` pulse.
- done, output, 1, one-cycle pulse when a scan completes.

## Operation
- States:
  - IDLE: waits for `start`. On `start`, latch `base_addr` and `word_count`, then go to ISSUE, or to FINISH if `word_count` is 0.
  - ISSUE: issues reads.
  - DRAIN: waits for in-flight reads to land and the FIFO to empty.
  - FINISH: one cycle; pulses `done` and returns to IDLE.
- Issue rule in ISSUE: one address per cycle, only when credit > 0.
  - credit = FIFO_DEPTH − fifo_count − inflight, where inflight is the popcount of a READ_LAT-deep valid shift register.
  - On each issue: `parallelAddress` ← current address, address += 1 (wraps modulo 2^ADDR_W), remaining −= 1.
  - When remaining reaches 0 after an issue, go to DRAIN.
- `parallelAddress` holds its last value when not issuing. It does not return to 0 between scans.
- Capture: when the valid shift register's oldest bit is set, write `q` into the FIFO. Issue is credit-limited, so the FIFO is never written while full. Overflow cannot occur; the bench asserts it.
- FIFO: show-ahead. `m_data` is the head entry. `m_valid` = (fifo_count != 0). A pop occurs on `m_valid && m_ready`. A simultaneous push and pop leaves the count unchanged.
- `m_last`: high while the head entry is the final word of the scan. Track it with a per-entry tag bit, set on the capture made when the captured-word counter reaches `word_count`.
- DRAIN → FINISH when inflight == 0 and fifo_count == 0. That is the cycle after the `m_last` beat is accepted.
- `start` outside IDLE is ignored. `base_addr` and `word_count` changes after latching have no effect.
- Reset (any cycle, including mid-scan) immediately:
  - sets state to IDLE;
  - clears the FIFO, in-flight bits and counters;
  - drives `parallelAddress` = 0, `m_valid` = 0, `m_last` = 0, `m_data` = 0, `busy` = 0, `done` = 0.
  - Reads in flight at reset are discarded.

## Timing
- Cycle 0: `start` high in IDLE. Cycle 1: first address on `parallelAddress`, `busy` = 1.
- An address issued in cycle k has its `q` sampled at the clk edge ending cycle k+READ_LAT. The word appears on `m_data` with `m_valid` = 1 in cycle k+READ_LAT+1.
- With `m_ready` held high and FIFO_DEPTH ≥ READ_LAT+1, throughput is one word per cycle.
  - First word valid in cycle READ_LAT+2.
  - Last word (N) valid in cycle N+READ_LAT+1.
  - `done` in cycle N+READ_LAT+2, with `busy` still high in that cycle.
  - IDLE again (`busy` = 0) in cycle N+READ_LAT+3.
- `word_count` = 0: `busy` = 1 and `done` = 1 in cycle 1; no address issued; no `m_valid`.
- Under backpressure, issue stalls within one cycle of credit reaching 0. No word is lost or duplicated.
- Next `start` is accepted in the first IDLE cycle after `done`.

## Test plan
- Basic scan: READ_LAT = 2, `base_addr` = 0x000100, `word_count` = 4, memory model returns `q` = low 16 address bits, `m_ready` = 1.
  - Addresses 0x100..0x103 in cycles 1–4.
  - `m_data` 0x0100..0x0103 in cycles 4–7; `m_last` only in cycle 7.
  - `done` in cycle 8.
- Backpressure: `word_count` = 16, `m_ready` toggling 1,0,0,1.
  - All 16 words arrive in order with no overflow.
  - Issue stalls while credit = 0; inflight + fifo_count ≤ 4 every cycle.
- Zero length: `word_count` = 0 → `done` pulse in cycle 1, `parallelAddress` unchanged, `m_valid` never high.
- Address wrap: `base_addr` = 0xFFFFFE, `word_count` = 4 → addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- Reset mid-scan: assert `rst` in the cycle after the 3rd word is accepted.
  - All outputs 0 immediately.
  - A new `start` then runs a clean scan with no stale words from the aborted one.
- Ignored start: pulse `start` with different `base_addr` during ISSUE → the current scan completes unchanged; no second scan follows.
